uart_tx: RTL and testbench

Serial transmitter stage for the UART path: accepts one byte per `transmit` pulse from `uart_controller`'s TX FIFO drain logic and shifts it out on `tx` as an asynchronous frame (start, data LSB-first, optional parity, stop). It produces `is_transmitting`, which the controller uses to decide when to pop the next FIFO entry. Bit timing uses the same quarter-bit prescaler convention as the rest of the UART path: one bit = 4 × `CLOCK_DIVIDE` clocks.

---
 rtl/uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Function : Asynchronous serial transmitter. Sends one frame per accepted
//             request: start bit, DATA_BITS data bits LSB-first, optional
//             parity bit, STOP_BITS stop bits. One bit lasts
//             4 * CLOCK_DIVIDE clocks (quarter-bit prescaler convention).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
   parameter int CLOCK_DIVIDE = 108,  // clocks per quarter-bit tick, >= 1
   parameter int DATA_BITS    = 8,    // 5..8
   parameter int PARITY       = 0,    // 0 none, 1 odd, 2 even
   parameter int STOP_BITS    = 1     // 1 or 2
) (
   input  logic       clk,
   input  logic       rst,             // asynchronous, active-low
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       is_transmitting,
   output logic       tx_done
);

   // A divide of 1 still needs a 1-bit prescaler register.
   localparam int PW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

   localparam logic [PW-1:0] c_presc_load = PW'(CLOCK_DIVIDE - 1);
   localparam logic [2:0]    c_last_data  = 3'(DATA_BITS - 1);
   localparam logic [2:0]    c_last_stop  = 3'(STOP_BITS - 1);
   localparam logic [7:0]    c_data_mask  = 8'((16'd1 << DATA_BITS) - 16'd1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state,   w_state_n;
   logic [PW-1:0]   r_presc,   w_presc_n;
   logic [1:0]      r_quarter, w_quarter_n;
   logic [2:0]      r_bit_cnt, w_bit_cnt_n;
   logic [7:0]      r_shift,   w_shift_n;
   logic            r_parity,  w_parity_n;
   logic            r_tx,      w_tx_n;
   logic            r_busy,    w_busy_n;
   logic            r_done,    w_done_n;

   logic            w_tick;
   logic            w_bit_end;
   logic            w_xor;

   assign w_tick    = (r_presc == '0);
   assign w_bit_end = w_tick && (r_quarter == 2'd3);
   // Parity is fixed at acceptance so the shift register is free to shift.
   assign w_xor     = ^(tx_byte & c_data_mask);

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_quarter <= 2'd0;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_presc   <= w_presc_n;
         r_quarter <= w_quarter_n;
         r_bit_cnt <= w_bit_cnt_n;
         r_shift   <= w_shift_n;
         r_parity  <= w_parity_n;
         r_tx      <= w_tx_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
      end
   end

   // Next-state, bit timing and next registered output values.
   always_comb begin
      w_state_n   = r_state;
      w_presc_n   = r_presc;
      w_quarter_n = r_quarter;
      w_bit_cnt_n = r_bit_cnt;
      w_shift_n   = r_shift;
      w_parity_n  = r_parity;
      w_tx_n      = r_tx;
      w_busy_n    = r_busy;
      w_done_n    = 1'b0;

      // Prescaler and quarter counter run whenever a frame is in flight.
      if (r_state != S_IDLE) begin
         if (w_tick) begin
            w_presc_n   = c_presc_load;
            w_quarter_n = r_quarter + 2'd1;
         end else begin
            w_presc_n   = r_presc - 1'b1;
         end
      end

      case (r_state)
         S_IDLE: begin
            w_tx_n   = 1'b1;
            w_busy_n = 1'b0;
            if (transmit) begin
               w_state_n   = S_START;
               w_shift_n   = tx_byte;
               w_parity_n  = (PARITY == 1) ? ~w_xor : w_xor;
               w_presc_n   = c_presc_load;
               w_quarter_n = 2'd0;
               w_bit_cnt_n = 3'd0;
               w_tx_n      = 1'b0;
               w_busy_n    = 1'b1;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_state_n   = S_DATA;
               w_bit_cnt_n = 3'd0;
               w_tx_n      = r_shift[0];
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               w_shift_n = {1'b0, r_shift[7:1]};
               if (r_bit_cnt == c_last_data) begin
                  w_bit_cnt_n = 3'd0;
                  if (PARITY != 0) begin
                     w_state_n = S_PARITY;
                     w_tx_n    = r_parity;
                  end else begin
                     w_state_n = S_STOP;
                     w_tx_n    = 1'b1;
                  end
               end else begin
                  w_bit_cnt_n = r_bit_cnt + 3'd1;
                  w_tx_n      = r_shift[1];
               end
            end
         end

         S_PARITY: begin
            if (w_bit_end) begin
               w_state_n   = S_STOP;
               w_bit_cnt_n = 3'd0;
               w_tx_n      = 1'b1;
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               if (r_bit_cnt == c_last_stop) begin
                  w_state_n   = S_IDLE;
                  w_busy_n    = 1'b0;
                  w_done_n    = 1'b1;
                  w_bit_cnt_n = 3'd0;
               end else begin
                  w_bit_cnt_n = r_bit_cnt + 3'd1;
               end
               w_tx_n = 1'b1;
            end
         end

         default: begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
            w_busy_n  = 1'b0;
         end
      endcase
   end

   assign tx              = r_tx;
   assign is_transmitting = r_busy;
   assign tx_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Function : Self-checking bench for uart_tx. Three configurations run side
//             by side on shared stimulus; a frame-level reference model
//             predicts tx / is_transmitting / tx_done on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   localparam int NDUT = 3;
   localparam int C_CD  [NDUT] = '{2, 2, 1};
   localparam int C_DB  [NDUT] = '{8, 8, 7};
   localparam int C_PAR [NDUT] = '{0, 2, 1};
   localparam int C_SB  [NDUT] = '{1, 2, 1};

   logic            clk = 1'b0;
   logic            rst;
   logic            transmit = 1'b0;
   logic [7:0]      tx_byte  = 8'd0;
   logic [NDUT-1:0] tx, busy, done;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   uart_tx #(.CLOCK_DIVIDE(C_CD[0]), .DATA_BITS(C_DB[0]), .PARITY(C_PAR[0]), .STOP_BITS(C_SB[0])) u_dut0 (
      .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
      .tx(tx[0]), .is_transmitting(busy[0]), .tx_done(done[0]));
   uart_tx #(.CLOCK_DIVIDE(C_CD[1]), .DATA_BITS(C_DB[1]), .PARITY(C_PAR[1]), .STOP_BITS(C_SB[1])) u_dut1 (
      .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
      .tx(tx[1]), .is_transmitting(busy[1]), .tx_done(done[1]));
   uart_tx #(.CLOCK_DIVIDE(C_CD[2]), .DATA_BITS(C_DB[2]), .PARITY(C_PAR[2]), .STOP_BITS(C_SB[2])) u_dut2 (
      .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
      .tx(tx[2]), .is_transmitting(busy[2]), .tx_done(done[2]));

   // ---------------- reference model (frame level) ----------------
   function automatic int frame_len(int i);
      return (1 + C_DB[i] + ((C_PAR[i] != 0) ? 1 : 0) + C_SB[i]) * 4 * C_CD[i];
   endfunction

   // Whole frame as a bit list, index 0 = start bit; trailing ones are stop.
   function automatic logic [11:0] build_frame(int i, logic [7:0] b);
      logic [11:0] f;
      logic        x;
      f    = '1;
      f[0] = 1'b0;
      x    = 1'b0;
      for (int j = 0; j < C_DB[i]; j++) begin
         f[1+j] = b[j];
         x      = x ^ b[j];
      end
      if (C_PAR[i] == 2)      f[1+C_DB[i]] = x;
      else if (C_PAR[i] == 1) f[1+C_DB[i]] = ~x;
      return f;
   endfunction

   logic [11:0] m_bits [NDUT];
   int          m_cnt  [NDUT];
   logic        m_busy [NDUT];
   logic        m_done [NDUT];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NDUT; i++) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_cnt[i]  <= 0;
            m_bits[i] <= '1;
         end
      end else begin
         for (int i = 0; i < NDUT; i++) begin
            m_done[i] <= 1'b0;
            if (m_busy[i]) begin
               m_cnt[i] <= m_cnt[i] + 1;
               if (m_cnt[i] + 1 == frame_len(i)) begin
                  m_busy[i] <= 1'b0;
                  m_done[i] <= 1'b1;
               end
            end else if (transmit) begin
               m_busy[i] <= 1'b1;
               m_cnt[i]  <= 0;
               m_bits[i] <= build_frame(i, tx_byte);
            end
         end
      end
   end

   function automatic logic exp_tx(int i);
      if (!m_busy[i]) return 1'b1;
      return m_bits[i][m_cnt[i] / (4 * C_CD[i])];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Cycle-by-cycle comparison of {tx, busy, done} against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NDUT; i++)
            check($sformatf("cycle_dut%0d_txbusydone", i),
                  int'({tx[i], busy[i], done[i]}),
                  int'({exp_tx(i), m_busy[i], m_done[i]}));
      end
   end

   // ---------------- stimulus helpers ----------------
   // Pulse transmit for one edge; returns at the negedge after acceptance edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      transmit = 1'b1;
      tx_byte  = b;
      @(negedge clk);
      transmit = 1'b0;
      tx_byte  = 8'($urandom);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (busy == '0 && done == '0) return;
      end
      check("wait_idle_timeout", 1, 0);
   endtask

   // Send one byte and measure the target DUT's frame at bit centres.
   task automatic measure(input int d, input logic [7:0] b, input int exp_par,
                          input int exp_len, input string tag);
      logic [7:0] got;
      logic       par;
      int         done_at, busy_cnt, done_cnt, k, bt;
      got = 8'd0; par = 1'b0; done_at = -1; busy_cnt = 0; done_cnt = 0;
      bt  = 4 * C_CD[d];
      send(b);
      for (int c = 0; c < exp_len + 10; c++) begin
         if (c > 0) @(negedge clk);
         if (busy[d]) busy_cnt++;
         if (done[d]) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (c % bt == bt / 2) begin
            k = c / bt;
            if (k >= 1 && k <= C_DB[d]) got[k-1] = tx[d];
            if (C_PAR[d] != 0 && k == C_DB[d] + 1) par = tx[d];
         end
      end
      check({tag, "_data"},    int'(got), int'(b & 8'((16'd1 << C_DB[d]) - 16'd1)));
      if (exp_par >= 0) check({tag, "_parity"}, int'(par), exp_par);
      check({tag, "_done_at"}, done_at,   exp_len);
      check({tag, "_busy_len"}, busy_cnt, exp_len);
      check({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         exp_par;   // -1 when no parity bit
      int         exp_len;
   } vec_t;

   vec_t tbl [6];

   initial begin
      bit          exp_seq [10];
      logic [7:0]  got;
      int          mism, low_cnt;

      tbl[0] = '{0, 8'h55, -1, 80};
      tbl[1] = '{1, 8'h07,  1, 96};   // even parity of three ones
      tbl[2] = '{2, 8'h07,  0, 40};   // odd parity of three ones
      tbl[3] = '{0, 8'hA3, -1, 80};
      tbl[4] = '{1, 8'h00,  0, 96};
      tbl[5] = '{2, 8'h80,  1, 40};   // bit 7 not sent in 7-bit frame

      // Reset state
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("reset_tx_dut%0d", i),   int'(tx[i]),   1);
         check($sformatf("reset_busy_dut%0d", i), int'(busy[i]), 0);
         check($sformatf("reset_done_dut%0d", i), int'(done[i]), 0);
      end
      rst    = 1'b1;
      chk_en = 1'b1;

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         wait_idle();
         measure(tbl[v].dut, tbl[v].data, tbl[v].exp_par, tbl[v].exp_len,
                 $sformatf("vec%0d", v));
      end

      // 0x55 waveform on 8N1, then back-to-back 0x0F on the tx_done cycle
      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      wait_idle();
      mism = 0; low_cnt = 0;
      send(8'h55);
      for (int c = 0; c < 82; c++) begin
         if (c > 0) @(negedge clk);
         if (c < 80 && tx[0] != exp_seq[c/8]) mism++;
         if (!busy[0]) low_cnt++;
         if (c == 80) begin
            check("b2b_done_at_80", int'(done[0]), 1);
            transmit = 1'b1;
            tx_byte  = 8'h0F;
         end else begin
            transmit = 1'b0;
         end
         if (c == 81) check("b2b_second_start", int'(tx[0]), 0);
      end
      check("pattern_55_mismatches", mism, 0);
      check("b2b_busy_low_cycles", low_cnt, 1);

      // Busy reject: 0xFF requests during a 0xA3 frame are ignored
      wait_idle();
      got = 8'd0; mism = 0;
      send(8'hA3);
      for (int c = 0; c < 90; c++) begin
         if (c > 0) @(negedge clk);
         if (done[0]) mism++;
         if (c % 8 == 4 && c / 8 >= 1 && c / 8 <= 8) got[c/8-1] = tx[0];
         transmit = (c == 5 || c == 40);
         tx_byte  = (c == 5 || c == 40) ? 8'hFF : 8'h00;
      end
      transmit = 1'b0;
      check("busy_reject_data", int'(got), 8'hA3);
      check("busy_reject_done_cnt", mism, 1);

      // Asynchronous reset 30 clocks into a frame
      wait_idle();
      send(8'hC3);
      repeat (30) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_tx", int'(tx[0]), 1);
      check("async_rst_busy", int'(busy[0]), 0);
      check("async_rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      measure(0, 8'h96, -1, 80, "post_reset");

      // Random requests, including many while busy
      wait_idle();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         transmit = ($urandom_range(0, 15) == 0);
         tx_byte  = 8'($urandom);
      end
      transmit = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
